// File: rtl/nes_apu_frame_counter.sv
// APU frame sequencer: quarter/half-frame pulses, frame IRQ, $4017 delayed reset, $4015 read clear.
// Define APU_FRAME_PAL_EN for the PAL step table; NTSC is the default build.
module nes_apu_frame_counter #(
  parameter int CNT_W = 16
) (
  input  logic       clk_nes,
  input  logic       rst_master_n,
  input  logic       cpu_ce,
  input  logic       wr_4017,
  input  logic [7:0] wr_data,
  input  logic       rd_4015,
  output logic       quarter_frame,
  output logic       half_frame,
  output logic       frame_irq
);

`ifdef APU_FRAME_PAL_EN
  localparam logic [CNT_W-1:0] STEP_Q1 = CNT_W'(32'd8313);
  localparam logic [CNT_W-1:0] STEP_H1 = CNT_W'(32'd16627);
  localparam logic [CNT_W-1:0] STEP_Q3 = CNT_W'(32'd24939);
  localparam logic [CNT_W-1:0] LAST_4  = CNT_W'(32'd33253);
  localparam logic [CNT_W-1:0] LAST_5  = CNT_W'(32'd41565);
`else
  localparam logic [CNT_W-1:0] STEP_Q1 = CNT_W'(32'd7457);
  localparam logic [CNT_W-1:0] STEP_H1 = CNT_W'(32'd14913);
  localparam logic [CNT_W-1:0] STEP_Q3 = CNT_W'(32'd22371);
  localparam logic [CNT_W-1:0] LAST_4  = CNT_W'(32'd29829);
  localparam logic [CNT_W-1:0] LAST_5  = CNT_W'(32'd37281);
`endif
  localparam logic [CNT_W-1:0] IRQ_PRE = LAST_4 - CNT_W'(32'd1);

  logic [CNT_W-1:0] cnt_r, cnt_n_s;
  logic             mode_r, mode_n_s;
  logic             inhibit_r, inhibit_n_s;
  logic             irq_r, irq_n_s;
  logic             parity_r, parity_n_s;
  logic             pend_r, pend_n_s;
  logic             pend_mode_r, pend_mode_n_s;
  logic [2:0]       dly_r, dly_n_s;
  logic             quarter_r, quarter_n_s;
  logic             half_r, half_n_s;

  logic [CNT_W-1:0] last_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             wrap_s;
  logic             apply_s;
  logic             inhibit_eff_s;
  logic             step_h_s;
  logic             step_q_s;
  logic             irq_set_s;

  // Next-state logic: normal stepping, pending-write apply, IRQ set/clear
  always_comb begin
    last_s        = mode_r ? LAST_5 : LAST_4;
    wrap_s        = (cnt_r == last_s);
    cnt_inc_s     = wrap_s ? '0 : (cnt_r + CNT_W'(32'd1));
    // A write landing on the apply edge restarts the delay instead of applying
    apply_s       = cpu_ce && pend_r && !wr_4017 && (dly_r == 3'd1);
    inhibit_eff_s = wr_4017 ? wr_data[6] : inhibit_r;
    step_h_s      = (cnt_inc_s == STEP_H1) || (cnt_inc_s == last_s);
    step_q_s      = (cnt_inc_s == STEP_Q1) || (cnt_inc_s == STEP_Q3) || step_h_s;

    cnt_n_s       = cnt_r;
    mode_n_s      = mode_r;
    inhibit_n_s   = inhibit_r;
    parity_n_s    = parity_r;
    pend_n_s      = pend_r;
    pend_mode_n_s = pend_mode_r;
    dly_n_s       = dly_r;
    quarter_n_s   = 1'b0;
    half_n_s      = 1'b0;
    irq_set_s     = 1'b0;

    if (cpu_ce) begin
      parity_n_s = ~parity_r;
    end else begin
      parity_n_s = parity_r;
    end

    if (apply_s) begin
      cnt_n_s     = '0;
      mode_n_s    = pend_mode_r;
      pend_n_s    = 1'b0;
      dly_n_s     = 3'd0;
      quarter_n_s = pend_mode_r;
      half_n_s    = pend_mode_r;
    end else if (cpu_ce) begin
      cnt_n_s     = cnt_inc_s;
      quarter_n_s = step_q_s;
      half_n_s    = step_h_s;
      irq_set_s   = !mode_r && !inhibit_eff_s &&
                    ((cnt_inc_s == IRQ_PRE) || (cnt_inc_s == LAST_4) || wrap_s);
      if (pend_r && !wr_4017) begin
        dly_n_s = dly_r - 3'd1;
      end else begin
        dly_n_s = dly_r;
      end
    end else begin
      cnt_n_s = cnt_r;
    end

    if (wr_4017) begin
      inhibit_n_s   = wr_data[6];
      pend_n_s      = 1'b1;
      pend_mode_n_s = wr_data[7];
      dly_n_s       = parity_r ? 3'd3 : 3'd4;
    end else begin
      inhibit_n_s   = inhibit_r;
    end

    if (irq_set_s) begin
      irq_n_s = 1'b1;
    end else if (rd_4015 || inhibit_eff_s) begin
      irq_n_s = 1'b0;
    end else begin
      irq_n_s = irq_r;
    end
  end

  // State and output registers
  always_ff @(posedge clk_nes or negedge rst_master_n) begin
    if (!rst_master_n) begin
      cnt_r       <= '0;
      mode_r      <= 1'b0;
      inhibit_r   <= 1'b0;
      irq_r       <= 1'b0;
      parity_r    <= 1'b0;
      pend_r      <= 1'b0;
      pend_mode_r <= 1'b0;
      dly_r       <= 3'd0;
      quarter_r   <= 1'b0;
      half_r      <= 1'b0;
    end else begin
      cnt_r       <= cnt_n_s;
      mode_r      <= mode_n_s;
      inhibit_r   <= inhibit_n_s;
      irq_r       <= irq_n_s;
      parity_r    <= parity_n_s;
      pend_r      <= pend_n_s;
      pend_mode_r <= pend_mode_n_s;
      dly_r       <= dly_n_s;
      quarter_r   <= quarter_n_s;
      half_r      <= half_n_s;
    end
  end

  assign quarter_frame = quarter_r;
  assign half_frame    = half_r;
  assign frame_irq     = irq_r;

endmodule

// File: tb/tb_nes_apu_frame_counter.sv
// Directed bench for nes_apu_frame_counter (NTSC table): frame steps, IRQ, $4017/$4015 side effects.
module tb_nes_apu_frame_counter;
  logic       clk_nes = 1'b0;
  logic       rst_master_n;
  logic       cpu_ce;
  logic       wr_4017;
  logic [7:0] wr_data;
  logic       rd_4015;
  logic       quarter_frame;
  logic       half_frame;
  logic       frame_irq;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   q_acc, h_acc, irq_acc;
  int   pos;
  int   per_m;
  logic par_m;

  always #5 clk_nes = ~clk_nes;

  nes_apu_frame_counter #(.CNT_W(16)) dut (
    .clk_nes      (clk_nes),
    .rst_master_n (rst_master_n),
    .cpu_ce       (cpu_ce),
    .wr_4017      (wr_4017),
    .wr_data      (wr_data),
    .rd_4015      (rd_4015),
    .quarter_frame(quarter_frame),
    .half_frame   (half_frame),
    .frame_irq    (frame_irq)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // One clk_nes cycle: drive on negedge, sample 1 ns after posedge
  task automatic cyc(input logic ce, input logic wr, input logic [7:0] d, input logic rd);
    @(negedge clk_nes);
    cpu_ce = ce; wr_4017 = wr; wr_data = d; rd_4015 = rd;
    @(posedge clk_nes);
    #1;
    cpu_ce = 1'b0; wr_4017 = 1'b0; rd_4015 = 1'b0;
    q_acc   += int'(quarter_frame);
    h_acc   += int'(half_frame);
    irq_acc += int'(frame_irq);
    if (ce && rst_master_n) par_m = ~par_m;
  endtask

  task automatic run_until(input int last);
    int guard;
    guard = 0;
    q_acc = 0; h_acc = 0; irq_acc = 0;
    while (pos != last && guard < 50000) begin
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      pos = (pos == per_m - 1) ? 0 : pos + 1;
      guard++;
    end
    check_val($sformatf("reach_%0d", last), pos, last);
  endtask

  // One cpu_ce step with expected outputs, then one idle cycle where pulses must be low
  task automatic step(input string tag, input logic wr, input logic [7:0] d, input logic rd,
                      input int eq, input int eh, input int ei);
    cyc(1'b1, wr, d, rd);
    pos = (pos == per_m - 1) ? 0 : pos + 1;
    check_val({tag, "_q"}, int'(quarter_frame), eq);
    check_val({tag, "_h"}, int'(half_frame), eh);
    check_val({tag, "_irq"}, int'(frame_irq), ei);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check_val({tag, "_idle_q"}, int'(quarter_frame), 0);
    check_val({tag, "_idle_h"}, int'(half_frame), 0);
  endtask

  initial begin
    int n_dly;
    rst_master_n = 1'b0;
    cpu_ce = 1'b0; wr_4017 = 1'b0; wr_data = 8'h00; rd_4015 = 1'b0;
    per_m = 29830; pos = 0; par_m = 1'b0;

    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b1, 8'hc0, 1'b0);
    check_val("rst_q", int'(quarter_frame), 0);
    check_val("rst_h", int'(half_frame), 0);
    check_val("rst_irq", int'(frame_irq), 0);
    @(negedge clk_nes);
    rst_master_n = 1'b1;

    // Reach the first Q step, write 0x80 on that edge, then reset asynchronously
    run_until(7456);
    check_val("pre_q_cnt", q_acc, 0);
    check_val("pre_h_cnt", h_acc, 0);
    cyc(1'b1, 1'b1, 8'h80, 1'b0);
    check_val("first_q7457", int'(quarter_frame), 1);
    #1 rst_master_n = 1'b0;
    #1;
    check_val("async_rst_q", int'(quarter_frame), 0);
    check_val("async_rst_h", int'(half_frame), 0);
    check_val("async_rst_irq", int'(frame_irq), 0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    @(negedge clk_nes);
    rst_master_n = 1'b1;
    pos = 0; par_m = 1'b0;

    // 4-step frame: pending write was discarded, nothing before cnt 7457
    run_until(7456);
    check_val("post_rst_q_cnt", q_acc, 0);
    check_val("post_rst_h_cnt", h_acc, 0);
    step("a7457", 1'b0, 8'h00, 1'b0, 1, 0, 0);
    run_until(14912);
    check_val("a_q_gap1", q_acc, 0);
    step("a14913", 1'b0, 8'h00, 1'b0, 1, 1, 0);
    run_until(22370);
    check_val("a_h_gap2", h_acc, 0);
    step("a22371", 1'b0, 8'h00, 1'b0, 1, 0, 0);
    run_until(29827);
    check_val("a_irq_early", irq_acc, 0);
    check_val("a_q_gap3", q_acc, 0);
    step("a29828", 1'b0, 8'h00, 1'b0, 0, 0, 1);

    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check_val("rd_clear", int'(frame_irq), 0);
    step("a29829_rd", 1'b0, 8'h00, 1'b1, 1, 1, 1);

    // Inhibit write while irq=1; parity is 1 here so the reset lands on the 3rd cpu_ce
    cyc(1'b0, 1'b1, 8'h40, 1'b0);
    check_val("inh_clear", int'(frame_irq), 0);
    check_val("inh_par", int'(par_m), 1);
    step("inh_wrap", 1'b0, 8'h00, 1'b0, 0, 0, 0);
    step("inh_d1", 1'b0, 8'h00, 1'b0, 0, 0, 0);
    step("inh_apply", 1'b0, 8'h00, 1'b0, 0, 0, 0);
    pos = 0;

    // Write 0x00, then 0x80 two cpu_ce later with parity 0: delay restarts at 4
    check_val("w5_par", int'(par_m), 0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    step("w5_a", 1'b0, 8'h00, 1'b0, 0, 0, 0);
    step("w5_b", 1'b0, 8'h00, 1'b0, 0, 0, 0);
    cyc(1'b0, 1'b1, 8'h80, 1'b0);
    step("w5_c1", 1'b0, 8'h00, 1'b0, 0, 0, 0);
    step("w5_c2", 1'b0, 8'h00, 1'b0, 0, 0, 0);
    step("w5_c3", 1'b0, 8'h00, 1'b0, 0, 0, 0);
    step("w5_apply", 1'b0, 8'h00, 1'b0, 1, 1, 0);
    pos = 0; per_m = 37282;

    // 5-step frame with inhibit cleared: no irq anywhere
    run_until(7456);
    check_val("b_q_gap0", q_acc, 0);
    step("b7457", 1'b0, 8'h00, 1'b0, 1, 0, 0);
    run_until(14912);
    step("b14913", 1'b0, 8'h00, 1'b0, 1, 1, 0);
    run_until(22370);
    step("b22371", 1'b0, 8'h00, 1'b0, 1, 0, 0);
    run_until(37280);
    check_val("b_q_late", q_acc, 0);
    check_val("b_h_late", h_acc, 0);
    check_val("b_irq_none", irq_acc, 0);
    step("b37281", 1'b0, 8'h00, 1'b0, 1, 1, 0);
    step("b_wrap", 1'b0, 8'h00, 1'b0, 0, 0, 0);

    // Write 0x80 with parity 1: reset with Q+H on the 3rd following cpu_ce
    if (par_m == 1'b0) step("p_align", 1'b0, 8'h00, 1'b0, 0, 0, 0);
    cyc(1'b0, 1'b1, 8'h80, 1'b0);
    step("p1_c1", 1'b0, 8'h00, 1'b0, 0, 0, 0);
    step("p1_c2", 1'b0, 8'h00, 1'b0, 0, 0, 0);
    step("p1_apply", 1'b0, 8'h00, 1'b0, 1, 1, 0);
    pos = 0;

    // Write on a cpu_ce edge: that edge steps normally and is not counted in the delay
    n_dly = par_m ? 3 : 4;
    step("co_wr", 1'b1, 8'h80, 1'b0, 0, 0, 0);
    for (int k = 1; k < n_dly; k++) step($sformatf("co_c%0d", k), 1'b0, 8'h00, 1'b0, 0, 0, 0);
    step("co_apply", 1'b0, 8'h00, 1'b0, 1, 1, 0);
    step("co_after", 1'b0, 8'h00, 1'b0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
